// File: rtl/fir_tcdm_bridge.sv
// -----------------------------------------------------------------------------
// fir_tcdm_bridge
//   Multi-channel TCDM request bridge between the FIR HWPE engine's flat TCDM
//   master ports and the cluster interconnect. Each channel buffers requests in
//   a registered FIFO (no fall-through), limits its in-flight reads to MAX_OUT
//   and forwards read responses to the engine with zero latency.
//
//   Optional build macro: FIR_TCDM_BRIDGE_STATS_EN
//     defined   -> per-channel saturating grant-stall counters on stall_cnt_o
//     undefined -> stall_cnt_o tied to zero (port list unchanged)
//
// Ports (all buses are MP channels concatenated, channel c at slice c):
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous flush of every channel
//   eng_req/gnt/add/wen/be/data       engine-side request port (wen: 1=read)
//   eng_r_data/eng_r_valid            read response towards the engine
//   tcdm_req/gnt/add/wen/be/data      interconnect-side request port
//   tcdm_r_data/tcdm_r_valid          read response from the interconnect
//   stall_cnt_o          per-channel 32-bit stall counters
// -----------------------------------------------------------------------------
module fir_tcdm_bridge #(
    parameter int unsigned MP      = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [MP-1:0]        eng_req,
    output logic [MP-1:0]        eng_gnt,
    input  logic [MP*AW-1:0]     eng_add,
    input  logic [MP-1:0]        eng_wen,
    input  logic [MP*DW/8-1:0]   eng_be,
    input  logic [MP*DW-1:0]     eng_data,
    output logic [MP*DW-1:0]     eng_r_data,
    output logic [MP-1:0]        eng_r_valid,
    output logic [MP-1:0]        tcdm_req,
    input  logic [MP-1:0]        tcdm_gnt,
    output logic [MP*AW-1:0]     tcdm_add,
    output logic [MP-1:0]        tcdm_wen,
    output logic [MP*DW/8-1:0]   tcdm_be,
    output logic [MP*DW-1:0]     tcdm_data,
    input  logic [MP*DW-1:0]     tcdm_r_data,
    input  logic [MP-1:0]        tcdm_r_valid,
    output logic [MP*32-1:0]     stall_cnt_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } req_t;

    // Holds grant low through reset and the first edge after release, so the
    // engine never sees a grant while the bridge is still in reset.
    logic r_alive;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_alive <= 1'b0;
        else         r_alive <= 1'b1;
    end

    // Responses are pure wires: forwarded regardless of the outstanding count.
    assign eng_r_valid = tcdm_r_valid;
    assign eng_r_data  = tcdm_r_data;

    for (genvar c = 0; c < MP; c++) begin : g_ch
        req_t            r_mem [DEPTH];
        logic [PW-1:0]   r_wr_ptr;
        logic [PW-1:0]   r_rd_ptr;
        logic [CW-1:0]   r_count;
        logic [OW-1:0]   r_out_cnt;
        req_t            w_in;
        req_t            w_head;
        logic            w_full;
        logic            w_empty;
        logic            w_req;
        logic            w_gnt;
        logic            w_push;
        logic            w_pop;
        logic            w_rd_hs;
        logic            w_rvalid;

        assign w_in     = '{add:  eng_add[c*AW +: AW], wen: eng_wen[c],
                            be:   eng_be[c*BW +: BW],  data: eng_data[c*DW +: DW]};
        assign w_head   = r_mem[r_rd_ptr];
        assign w_full   = (r_count == CW'(DEPTH));
        assign w_empty  = (r_count == '0);
        // A read at the head waits while MAX_OUT reads are already in flight.
        assign w_req    = !w_empty && !(w_head.wen && (r_out_cnt == OW'(MAX_OUT)));
        assign w_gnt    = r_alive && !w_full && !clear_i;
        assign w_push   = eng_req[c] && w_gnt;
        assign w_pop    = w_req && tcdm_gnt[c];
        assign w_rd_hs  = w_pop && w_head.wen;
        assign w_rvalid = tcdm_r_valid[c];

        assign eng_gnt[c]              = w_gnt;
        assign tcdm_req[c]             = w_req;
        assign tcdm_add[c*AW +: AW]    = w_head.add;
        assign tcdm_wen[c]             = w_head.wen;
        assign tcdm_be[c*BW +: BW]     = w_head.be;
        assign tcdm_data[c*DW +: DW]   = w_head.data;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                // NOTE: the storage is reset too, so the payload outputs read
                // zero out of reset; at this depth the extra reset nets are cheap.
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_push) r_mem[r_wr_ptr] <= w_in;

                if (clear_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                    if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: ;
                    endcase
                end

                // Keeps tracking through clear_i so late responses still retire.
                if (w_rd_hs && !w_rvalid)
                    r_out_cnt <= r_out_cnt + OW'(1);
                else if (!w_rd_hs && w_rvalid && (r_out_cnt != '0))
                    r_out_cnt <= r_out_cnt - OW'(1);
            end
        end

`ifdef FIR_TCDM_BRIDGE_STATS_EN
        logic [31:0] r_stall;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                r_stall <= '0;
            else if (clear_i)
                r_stall <= '0;
            else if (w_req && !tcdm_gnt[c] && (r_stall != 32'hFFFF_FFFF))
                r_stall <= r_stall + 32'd1;
        end

        assign stall_cnt_o[c*32 +: 32] = r_stall;
`else
        assign stall_cnt_o[c*32 +: 32] = 32'd0;
`endif
    end

endmodule

// File: tb/tb_fir_tcdm_bridge.sv
// -----------------------------------------------------------------------------
// tb_fir_tcdm_bridge
//   Self-checking bench for fir_tcdm_bridge. A queue-per-channel reference
//   model tracks the expected request stream, outstanding reads and stall
//   counts; every cycle the DUT outputs are compared against it, and each
//   scenario task adds its own directed checks.
// -----------------------------------------------------------------------------
module tb_fir_tcdm_bridge;

    localparam int MP      = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int BW      = DW / 8;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

`ifdef FIR_TCDM_BRIDGE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } ent_t;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                clear_i;
    logic [MP-1:0]       eng_req;
    logic [MP-1:0]       eng_gnt;
    logic [MP*AW-1:0]    eng_add;
    logic [MP-1:0]       eng_wen;
    logic [MP*BW-1:0]    eng_be;
    logic [MP*DW-1:0]    eng_data;
    logic [MP*DW-1:0]    eng_r_data;
    logic [MP-1:0]       eng_r_valid;
    logic [MP-1:0]       tcdm_req;
    logic [MP-1:0]       tcdm_gnt;
    logic [MP*AW-1:0]    tcdm_add;
    logic [MP-1:0]       tcdm_wen;
    logic [MP*BW-1:0]    tcdm_be;
    logic [MP*DW-1:0]    tcdm_data;
    logic [MP*DW-1:0]    tcdm_r_data;
    logic [MP-1:0]       tcdm_r_valid;
    logic [MP*32-1:0]    stall_cnt_o;

    fir_tcdm_bridge #(
        .MP(MP), .DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .eng_req(eng_req), .eng_gnt(eng_gnt), .eng_add(eng_add),
        .eng_wen(eng_wen), .eng_be(eng_be), .eng_data(eng_data),
        .eng_r_data(eng_r_data), .eng_r_valid(eng_r_valid),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
        .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
        .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    ent_t        m_q   [MP][$];
    int          m_out [MP];
    longint      m_stall [MP];
    bit          m_alive;

    function automatic bit exp_req(int c);
        if (m_q[c].size() == 0) return 1'b0;
        return !(m_q[c][0].wen && (m_out[c] == MAX_OUT));
    endfunction

    function automatic bit exp_gnt(int c);
        return m_alive && (m_q[c].size() < DEPTH) && !clear_i;
    endfunction

    task automatic idle_inputs();
        clear_i      = 1'b0;
        eng_req      = '0;
        eng_add      = '0;
        eng_wen      = '0;
        eng_be       = '0;
        eng_data     = '0;
        tcdm_gnt     = '0;
        tcdm_r_data  = '0;
        tcdm_r_valid = '0;
    endtask

    task automatic push(int c, logic [AW-1:0] add, logic wen, logic [BW-1:0] be,
                        logic [DW-1:0] data);
        eng_req[c]           = 1'b1;
        eng_add[c*AW +: AW]  = add;
        eng_wen[c]           = wen;
        eng_be[c*BW +: BW]   = be;
        eng_data[c*DW +: DW] = data;
    endtask

    // Wait for the falling edge and compare every channel against the model.
    task automatic sample();
        @(negedge clk_i);
        for (int c = 0; c < MP; c++) begin
            bit   er;
            ent_t h;
            er = exp_req(c);
            n_vec++;
            if (tcdm_req[c] !== er) begin
                n_err++;
                $display("FAIL tcdm_req ch%0d t=%0t got %b exp %b", c, $time, tcdm_req[c], er);
            end
            if (er) begin
                h = m_q[c][0];
                n_vec++;
                if ({tcdm_add[c*AW +: AW], tcdm_wen[c], tcdm_be[c*BW +: BW],
                     tcdm_data[c*DW +: DW]} !== h) begin
                    n_err++;
                    $display("FAIL payload ch%0d t=%0t got add=%h wen=%b be=%h data=%h exp add=%h wen=%b be=%h data=%h",
                             c, $time, tcdm_add[c*AW +: AW], tcdm_wen[c], tcdm_be[c*BW +: BW],
                             tcdm_data[c*DW +: DW], h.add, h.wen, h.be, h.data);
                end
            end
            n_vec++;
            if (eng_gnt[c] !== exp_gnt(c)) begin
                n_err++;
                $display("FAIL eng_gnt ch%0d t=%0t got %b exp %b", c, $time, eng_gnt[c], exp_gnt(c));
            end
            n_vec++;
            if ({eng_r_valid[c], eng_r_data[c*DW +: DW]} !==
                {tcdm_r_valid[c], tcdm_r_data[c*DW +: DW]}) begin
                n_err++;
                $display("FAIL r_fwd ch%0d t=%0t got %b/%h exp %b/%h", c, $time, eng_r_valid[c],
                         eng_r_data[c*DW +: DW], tcdm_r_valid[c], tcdm_r_data[c*DW +: DW]);
            end
            n_vec++;
            if (stall_cnt_o[c*32 +: 32] !== (STATS_ON ? 32'(m_stall[c]) : 32'd0)) begin
                n_err++;
                $display("FAIL stall_cnt ch%0d t=%0t got %0d exp %0d", c, $time,
                         stall_cnt_o[c*32 +: 32], STATS_ON ? m_stall[c] : 0);
            end
        end
    endtask

    // Clock edge: advance the model with the inputs applied this cycle.
    task automatic advance();
        @(posedge clk_i);
        for (int c = 0; c < MP; c++) begin
            bit er, pop, rd, psh;
            er  = exp_req(c);
            pop = er && tcdm_gnt[c];
            rd  = pop && m_q[c][0].wen;
            psh = eng_req[c] && exp_gnt(c);
            if (clear_i) begin
                m_q[c].delete();
                m_stall[c] = 0;
            end else begin
                if (er && !tcdm_gnt[c] && m_stall[c] < 64'hFFFF_FFFF) m_stall[c]++;
                if (pop) void'(m_q[c].pop_front());
                if (psh) m_q[c].push_back({eng_add[c*AW +: AW], eng_wen[c],
                                           eng_be[c*BW +: BW], eng_data[c*DW +: DW]});
            end
            if (rd && !tcdm_r_valid[c]) m_out[c]++;
            else if (!rd && tcdm_r_valid[c] && m_out[c] > 0) m_out[c]--;
        end
        m_alive = 1'b1;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    // Asynchronous reset pulse; outputs are checked while reset is held.
    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        n_vec++;
        if ({tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data} !== '0) begin
            n_err++;
            $display("FAIL reset_tcdm t=%0t got req=%b add=%h", $time, tcdm_req, tcdm_add);
        end
        n_vec++;
        if (eng_gnt !== '0) begin
            n_err++;
            $display("FAIL reset_gnt t=%0t got %b exp 0", $time, eng_gnt);
        end
        n_vec++;
        if (stall_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_stall t=%0t got %h exp 0", $time, stall_cnt_o);
        end
        for (int c = 0; c < MP; c++) begin
            m_q[c].delete();
            m_out[c]   = 0;
            m_stall[c] = 0;
        end
        m_alive = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        sample();
        n_vec++;
        if (eng_gnt !== '1) begin
            n_err++;
            $display("FAIL post_reset_gnt t=%0t got %b exp 1111", $time, eng_gnt);
        end
        advance();
    endtask

    task automatic test_single_write();
        test_reset();
        tcdm_gnt[0] = 1'b1;
        push(0, 32'h100, 1'b0, 4'hF, 32'hCAFE_0001);
        sample();
        n_vec++;
        if (tcdm_req[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sw_no_fallthrough got %b exp 0", tcdm_req[0]);
        end
        advance();
        eng_req = '0;
        sample();
        n_vec++;
        if ({tcdm_req[0], tcdm_add[AW-1:0], tcdm_data[DW-1:0]} !== {1'b1, 32'h100, 32'hCAFE_0001}) begin
            n_err++;
            $display("FAIL sw_issue got req=%b add=%h data=%h exp 1/100/cafe0001",
                     tcdm_req[0], tcdm_add[AW-1:0], tcdm_data[DW-1:0]);
        end
        advance();
        sample();
        n_vec++;
        if (tcdm_req[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sw_empty got %b exp 0", tcdm_req[0]);
        end
        advance();
    endtask

    task automatic test_fill();
        logic [AW-1:0] adds [6];
        int g = 0;
        test_reset();
        for (int i = 0; i < 6; i++) begin
            adds[i] = AW'(32'h200 + i * 4);
            push(0, adds[i], 1'b0, BW'($urandom), DW'($urandom));
            sample();
            if (eng_gnt[0]) g++;
            if (i >= 4) begin
                n_vec++;
                if (eng_gnt[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_full_gnt cycle %0d got %b exp 0", i, eng_gnt[0]);
                end
            end
            advance();
        end
        n_vec++;
        if (g != DEPTH) begin
            n_err++;
            $display("FAIL fill_grants got %0d exp %0d", g, DEPTH);
        end
        eng_req = '0;
        tcdm_gnt[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sample();
            n_vec++;
            if ({tcdm_req[0], tcdm_add[AW-1:0]} !== {1'b1, adds[i]}) begin
                n_err++;
                $display("FAIL fill_order pop %0d got req=%b add=%h exp add=%h",
                         i, tcdm_req[0], tcdm_add[AW-1:0], adds[i]);
            end
            if (i == 1) begin
                n_vec++;
                if (eng_gnt[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL fill_regrant got %b exp 1", eng_gnt[0]);
                end
            end
            advance();
        end
        step();
    endtask

    task automatic test_read_throttle();
        int issued = 0;
        logic [DW-1:0] rd;
        test_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, AW'(32'h300 + i * 4), 1'b1, 4'hF, '0);
            step();
        end
        eng_req = '0;
        tcdm_gnt[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (tcdm_req[0] && tcdm_gnt[0]) issued++;
            advance();
        end
        n_vec++;
        if (issued != MAX_OUT) begin
            n_err++;
            $display("FAIL thr_issued got %0d exp %0d", issued, MAX_OUT);
        end
        rd = DW'($urandom);
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[DW-1:0] = rd;
        sample();
        n_vec++;
        if ({tcdm_req[0], eng_r_valid[0], eng_r_data[DW-1:0]} !== {1'b0, 1'b1, rd}) begin
            n_err++;
            $display("FAIL thr_held_resp got req=%b rv=%b rdata=%h exp 0/1/%h",
                     tcdm_req[0], eng_r_valid[0], eng_r_data[DW-1:0], rd);
        end
        advance();
        tcdm_r_valid[0] = 1'b0;
        sample();
        n_vec++;
        if ({tcdm_req[0], tcdm_add[AW-1:0]} !== {1'b1, 32'h308}) begin
            n_err++;
            $display("FAIL thr_third got req=%b add=%h exp 1/308", tcdm_req[0], tcdm_add[AW-1:0]);
        end
        advance();
        tcdm_r_valid[0] = 1'b1;
        repeat (2) step();
        tcdm_r_valid[0] = 1'b0;
        step();
    endtask

    task automatic test_independence();
        int k = 0;
        test_reset();
        tcdm_gnt[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            eng_req = '0;
            if (i < 8) push(0, AW'(32'h1000 + i * 4), 1'b0, 4'hF, DW'($urandom));
            if (i < 2) push(1, AW'(32'h2000 + i * 4), 1'b0, 4'hF, DW'($urandom));
            sample();
            if (tcdm_req[0]) begin
                n_vec++;
                if (tcdm_add[AW-1:0] !== AW'(32'h1000 + k * 4)) begin
                    n_err++;
                    $display("FAIL ind_order %0d got %h exp %h", k, tcdm_add[AW-1:0], 32'h1000 + k * 4);
                end
                k++;
            end
            advance();
        end
        sample();
        n_vec++;
        if (k != 8) begin
            n_err++;
            $display("FAIL ind_count got %0d exp 8", k);
        end
        n_vec++;
        if ({tcdm_req[1], tcdm_add[AW +: AW], eng_gnt[1]} !== {1'b1, 32'h2000, 1'b1}) begin
            n_err++;
            $display("FAIL ind_ch1 got req=%b add=%h gnt=%b exp 1/2000/1",
                     tcdm_req[1], tcdm_add[AW +: AW], eng_gnt[1]);
        end
        advance();
    endtask

    task automatic test_clear();
        int issued = 0;
        logic [DW-1:0] rd;
        test_reset();
        tcdm_gnt[0] = 1'b1;
        push(0, 32'h400, 1'b1, 4'hF, '0);
        step();
        eng_req = '0;
        step();
        tcdm_gnt[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(0, AW'(32'h500 + i * 4), 1'b0, 4'h3, DW'($urandom));
            step();
        end
        eng_req = '0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        sample();
        n_vec++;
        if ({tcdm_req[0], eng_gnt[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL clr_flush got req=%b gnt=%b exp 0/1", tcdm_req[0], eng_gnt[0]);
        end
        advance();
        rd = DW'($urandom);
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[DW-1:0] = rd;
        sample();
        n_vec++;
        if ({eng_r_valid[0], eng_r_data[DW-1:0]} !== {1'b1, rd}) begin
            n_err++;
            $display("FAIL clr_late_resp got %b/%h exp 1/%h", eng_r_valid[0], eng_r_data[DW-1:0], rd);
        end
        advance();
        tcdm_r_valid[0] = 1'b0;
        tcdm_gnt[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            eng_req = '0;
            if (i < 2) push(0, AW'(32'h600 + i * 4), 1'b1, 4'hF, '0);
            sample();
            if (tcdm_req[0] && tcdm_gnt[0]) issued++;
            advance();
        end
        n_vec++;
        if (issued != 2) begin
            n_err++;
            $display("FAIL clr_out_cnt reads issued got %0d exp 2", issued);
        end
    endtask

    task automatic test_stats();
        test_reset();
        push(2, 32'h700, 1'b0, 4'hF, DW'($urandom));
        step();
        eng_req = '0;
        repeat (5) step();
        tcdm_gnt[2] = 1'b1;
        step();
        sample();
        n_vec++;
        if (stall_cnt_o[64 +: 32] !== (STATS_ON ? 32'd5 : 32'd0)) begin
            n_err++;
            $display("FAIL stats_ch2 got %0d exp %0d", stall_cnt_o[64 +: 32], STATS_ON ? 5 : 0);
        end
        advance();
        test_reset();
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) test_reset();
            for (int c = 0; c < MP; c++) begin
                eng_req[c]             = 1'($urandom_range(0, 1));
                eng_add[c*AW +: AW]    = AW'($urandom);
                eng_wen[c]             = 1'($urandom_range(0, 1));
                eng_be[c*BW +: BW]     = BW'($urandom);
                eng_data[c*DW +: DW]   = DW'($urandom);
                tcdm_gnt[c]            = ($urandom_range(0, 3) != 0);
                tcdm_r_valid[c]        = ($urandom_range(0, 3) == 0);
                tcdm_r_data[c*DW +: DW] = DW'($urandom);
            end
            clear_i = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_fill();
        test_read_throttle();
        test_independence();
        test_clear();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
